// File: rtl/sram_wb_pipelined.sv
// sram_wb_pipelined: Wishbone B4 pipelined slave around an inferred single-port SRAM.
//
// One request is accepted per edge where wb_cyc & wb_stb & !wb_stall. Each accepted request
// is followed by WAIT_STATES stalled cycles and then a single response cycle. The SRAM is
// accessed on the edge that enters the response cycle.
//
// Optional feature macro: SRAM_WB_ERR_EN
//   Defined: out-of-range addresses terminate with wb_err and leave memory and wb_datrd
//   untouched.
//   Undefined: wb_err is tied low and out-of-range addresses alias by index truncation.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   wb_adr    in   byte address (low log2(SEL_WIDTH) bits ignored)
//   wb_datwr  in   write data
//   wb_datrd  out  read data, holds the last read value
//   wb_we     in   1 = write, 0 = read
//   wb_sel    in   byte-lane enables for writes
//   wb_stb    in   strobe
//   wb_cyc    in   cycle valid
//   wb_stall  out  request cannot be accepted this cycle
//   wb_ack    out  normal termination pulse
//   wb_err    out  error termination pulse
module sram_wb_pipelined #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned           DEPTH       = 256,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_datwr,
  output logic [DATA_WIDTH-1:0] wb_datrd,
  input  logic                  wb_we,
  input  logic [SEL_WIDTH-1:0]  wb_sel,
  input  logic                  wb_stb,
  input  logic                  wb_cyc,
  output logic                  wb_stall,
  output logic                  wb_ack,
  output logic                  wb_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned LaneW    = $clog2(SEL_WIDTH);
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q;
  logic                  we_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  oor_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] datrd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IdxW-1:0]       bus_idx;
  logic                  bus_oor;
  logic                  from_latch;
  logic [IdxW-1:0]       req_idx;
  logic                  req_we;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic [DATA_WIDTH-1:0] req_dat;
  logic                  req_oor;

  // Word index relative to the base; upper bits only matter for the range check.
  assign offset  = wb_adr - BASE_ADDR;
  assign bus_idx = offset[LaneW +: IdxW];

`ifdef SRAM_WB_ERR_EN
  assign bus_oor = (wb_adr < BASE_ADDR) || ((offset >> (LaneW + IdxW)) != '0);
`else
  assign bus_oor = 1'b0;
`endif

  logic unused_offset;
  assign unused_offset = ^offset;

  assign wb_stall = (state_q == StWait);
  assign accept   = wb_cyc & wb_stb & ~wb_stall;
  assign wb_ack   = (state_q == StResp) & ~err_q;
  assign wb_datrd = datrd_q;

`ifdef SRAM_WB_ERR_EN
  assign wb_err = (state_q == StResp) & err_q;
`else
  assign wb_err = 1'b0;
`endif

  // With no wait states the access happens on the acceptance edge, so the live bus fields
  // are used; otherwise the fields latched at acceptance are.
  assign from_latch = (state_q == StWait);
  assign req_idx    = from_latch ? idx_q : bus_idx;
  assign req_we     = from_latch ? we_q  : wb_we;
  assign req_sel    = from_latch ? sel_q : wb_sel;
  assign req_dat    = from_latch ? dat_q : wb_datwr;
  assign req_oor    = from_latch ? oor_q : bus_oor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StResp;
            access  = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        // Dropping wb_cyc abandons the pending request, including any write.
        if (!wb_cyc) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      datrd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= bus_idx;
        we_q  <= wb_we;
        sel_q <= wb_sel;
        dat_q <= wb_datwr;
        oor_q <= bus_oor;
      end
      if (access) begin
        err_q <= req_oor;
      end
      if (access && !req_we && !req_oor) begin
        datrd_q <= mem[req_idx];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clock) begin
    if (access && req_we && !req_oor) begin
      for (int i = 0; i < int'(SEL_WIDTH); i++) begin
        if (req_sel[i]) begin
          mem[req_idx][8*i +: 8] <= req_dat[8*i +: 8];
        end
      end
    end
  end

endmodule
